next_level_model: RTL and testbench

- Parametrised, cycle-accurate behavioural model of the next cache level / main memory below L1.
- Accepts L1 miss and writeback commands through a valid/ready style interface and buffers them in a request queue.
- Services queued requests one at a time with a programmable fixed latency and returns a one-cycle response per request.
- Keeps per-command statistics counters for the simulation report.

---
 rtl/next_level_pkg.sv | 21 ++
 rtl/req_fifo.sv | 67 ++++++
 rtl/next_level_model.sv | 162 ++++++++++++++++
 tb/tb_next_level_model.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/next_level_pkg.sv
// Shared definitions for the next-level memory model: command codes,
// FSM state encoding and the request word width helper.
package next_level_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RWITM = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // A queued request is {addr, cmd}, command in the low two bits.
  function automatic int req_width(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous circular FIFO with push/pop, full/empty flags and occupancy.
// Push while full and pop while empty are ignored.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/next_level_model.sv
// Cycle-accurate model of the memory level below L1: queues L1 requests,
// serves them one at a time with a fixed latency, and keeps statistics.
module next_level_model
  import next_level_pkg::*;
#(
  parameter int ADDR_W  = 26,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] add_in,
  input  logic [1:0]        cmd_in,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_add,
  output logic [1:0]        resp_cmd,
  output logic              busy,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rwitm_count
);

  localparam int REQ_W = req_width(ADDR_W);
  localparam int QCNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LATENCY - 1);

  state_t            state_r, state_s;
  logic [TMR_W-1:0]  timer_r, timer_s;
  logic              pop_s;
  logic              accept_s;
  logic [REQ_W-1:0]  fifo_q_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [QCNT_W-1:0] fifo_count_s;
  logic [ADDR_W-1:0] svc_add_r;
  logic [1:0]        svc_cmd_r;
  logic              resp_valid_r;
  logic [ADDR_W-1:0] resp_add_r;
  logic [1:0]        resp_cmd_r;
  logic [CNT_W-1:0]  rd_count_r, wr_count_r, rwitm_count_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign req_ready   = !fifo_full_s;
  assign accept_s    = (cmd_in != CMD_NOP) && !fifo_full_s;
  assign busy        = (state_r != ST_IDLE) || (fifo_count_s != '0);
  assign resp_valid  = resp_valid_r;
  assign resp_add    = resp_add_r;
  assign resp_cmd    = resp_cmd_r;
  assign rd_count    = rd_count_r;
  assign wr_count    = wr_count_r;
  assign rwitm_count = rwitm_count_r;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_s),
    .wdata ({add_in, cmd_in}),
    .pop   (pop_s),
    .rdata (fifo_q_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Service FSM next-state logic: pop in IDLE, count down in BUSY, pulse in RESP.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          timer_s = TMR_LOAD;
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (timer_r == '0) begin
          state_s = ST_RESP;
        end else begin
          timer_s = timer_r - TMR_W'(1);
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, service register and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      timer_r      <= '0;
      svc_add_r    <= '0;
      svc_cmd_r    <= CMD_NOP;
      resp_valid_r <= 1'b0;
      resp_add_r   <= '0;
      resp_cmd_r   <= CMD_NOP;
    end else begin
      state_r      <= state_s;
      timer_r      <= timer_s;
      resp_valid_r <= (state_s == ST_RESP);
      if (pop_s) begin
        svc_add_r <= fifo_q_s[REQ_W-1:2];
        svc_cmd_r <= fifo_q_s[1:0];
      end else begin
        svc_add_r <= svc_add_r;
        svc_cmd_r <= svc_cmd_r;
      end
      // Response fields only change when a response is issued, otherwise hold.
      if ((state_r == ST_BUSY) && (state_s == ST_RESP)) begin
        resp_add_r <= svc_add_r;
        resp_cmd_r <= svc_cmd_r;
      end else begin
        resp_add_r <= resp_add_r;
        resp_cmd_r <= resp_cmd_r;
      end
    end
  end

  // Saturating per-command statistics; clear wins over a same-edge accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_r    <= '0;
      wr_count_r    <= '0;
      rwitm_count_r <= '0;
    end else if (clr_stats) begin
      rd_count_r    <= '0;
      wr_count_r    <= '0;
      rwitm_count_r <= '0;
    end else if (accept_s) begin
      case (cmd_in)
        CMD_READ:  rd_count_r    <= sat_inc(rd_count_r);
        CMD_WRITE: wr_count_r    <= sat_inc(wr_count_r);
        CMD_RWITM: rwitm_count_r <= sat_inc(rwitm_count_r);
        default: begin
          rd_count_r    <= rd_count_r;
          wr_count_r    <= wr_count_r;
          rwitm_count_r <= rwitm_count_r;
        end
      endcase
    end else begin
      rd_count_r    <= rd_count_r;
      wr_count_r    <= wr_count_r;
      rwitm_count_r <= rwitm_count_r;
    end
  end

endmodule

// File: tb/tb_next_level_model.sv
// Self-checking bench for next_level_model: a request-level timing model
// predicts acceptance, queue occupancy, response cycles and counter values.
module tb_next_level_model;
  import next_level_pkg::*;

  localparam int ADDR_W  = 26;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] add_in;
  logic [1:0]        cmd_in;
  logic              req_ready;
  logic              resp_valid;
  logic [ADDR_W-1:0] resp_add;
  logic [1:0]        resp_cmd;
  logic              busy;
  logic              clr_stats;
  logic [CNT_W-1:0]  rd_count, wr_count, rwitm_count;

  next_level_model #(
    .ADDR_W (ADDR_W), .DEPTH (DEPTH), .LATENCY (LATENCY), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .add_in (add_in), .cmd_in (cmd_in),
    .req_ready (req_ready), .resp_valid (resp_valid), .resp_add (resp_add),
    .resp_cmd (resp_cmd), .busy (busy), .clr_stats (clr_stats),
    .rd_count (rd_count), .wr_count (wr_count), .rwitm_count (rwitm_count)
  );

  always #5 clk = ~clk;

  // One accepted request: accept cycle, pop cycle, response cycle.
  typedef struct {
    int                a;
    int                p;
    int                r;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        cmd;
  } req_t;

  req_t              mq[$];
  int                t = 0;
  int                last_resp = -1000;
  int                checks = 0;
  int                errors = 0;
  int                n_acc = 0;
  int                n_seen = 0;
  logic              exp_valid, exp_ready, exp_busy;
  logic [ADDR_W-1:0] last_add;
  logic [1:0]        last_cmd;
  logic [CNT_W-1:0]  m_rd, m_wr, m_rw;

  // Derive expected outputs for cycle t from the list of accepted requests.
  function automatic void update_exp();
    int occ = 0;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].a < t && mq[i].p >= t) occ++;
      if (mq[i].a < t && t <= mq[i].r) exp_busy = 1'b1;
      if (mq[i].r == t) begin
        exp_valid = 1'b1;
        last_add  = mq[i].addr;
        last_cmd  = mq[i].cmd;
      end
    end
    exp_ready = (occ < DEPTH);
    while (mq.size() > 0 && mq[0].r < t) void'(mq.pop_front());
  endfunction

  function automatic void model_clear();
    mq.delete();
    last_resp = -1000;
    m_rd = '0; m_wr = '0; m_rw = '0;
    last_add = '0; last_cmd = CMD_NOP;
    update_exp();
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Drive one cycle of stimulus, advance the model, then compare every output.
  task automatic tick(input logic [1:0] c, input logic [ADDR_W-1:0] a,
                      input logic clr, output logic acc);
    req_t e;
    cmd_in = c; add_in = a; clr_stats = clr;
    acc = (c != CMD_NOP) && exp_ready && (rst_n === 1'b1);
    if (acc) begin
      e.a = t;
      e.p = (t + 1 > last_resp + 1) ? t + 1 : last_resp + 1;
      e.r = e.p + LATENCY + 1;
      e.addr = a; e.cmd = c;
      last_resp = e.r;
      mq.push_back(e);
      n_acc++;
    end
    if (clr) begin
      m_rd = '0; m_wr = '0; m_rw = '0;
    end else if (acc) begin
      if (c == CMD_READ)  m_rd = sat(m_rd);
      if (c == CMD_WRITE) m_wr = sat(m_wr);
      if (c == CMD_RWITM) m_rw = sat(m_rw);
    end
    @(posedge clk); #1;
    cmd_in = CMD_NOP; clr_stats = 1'b0;
    t++;
    update_exp();
    @(negedge clk);
    if (resp_valid === 1'b1) n_seen++;
    checks += 7;
    if (resp_valid !== exp_valid) begin errors++; $display("FAIL resp_valid cyc %0d: got %b want %b", t, resp_valid, exp_valid); end
    if (req_ready !== exp_ready) begin errors++; $display("FAIL req_ready cyc %0d: got %b want %b", t, req_ready, exp_ready); end
    if (busy !== exp_busy) begin errors++; $display("FAIL busy cyc %0d: got %b want %b", t, busy, exp_busy); end
    if ({resp_add, resp_cmd} !== {last_add, last_cmd}) begin errors++; $display("FAIL resp_data cyc %0d: got %h/%b want %h/%b", t, resp_add, resp_cmd, last_add, last_cmd); end
    if (rd_count !== m_rd) begin errors++; $display("FAIL rd_count cyc %0d: got %0d want %0d", t, rd_count, m_rd); end
    if (wr_count !== m_wr) begin errors++; $display("FAIL wr_count cyc %0d: got %0d want %0d", t, wr_count, m_wr); end
    if (rwitm_count !== m_rw) begin errors++; $display("FAIL rwitm_count cyc %0d: got %0d want %0d", t, rwitm_count, m_rw); end
  endtask

  // Hold a request until accepted, bounded; returns the accept cycle.
  task automatic send(input logic [1:0] c, input logic [ADDR_W-1:0] a, output int acc_cyc);
    logic acc = 1'b0;
    acc_cyc = -1;
    for (int k = 0; k < 100 && !acc; k++) begin
      acc_cyc = t;
      tick(c, a, 1'b0, acc);
    end
    checks++;
    if (!acc) begin errors++; $display("FAIL send_timeout: got no accept want accept of cmd %b", c); end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) tick(CMD_NOP, '0, 1'b0, acc);
  endtask

  task automatic test_reset();
    logic acc;
    rst_n = 1'b0; cmd_in = CMD_NOP; add_in = '0; clr_stats = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid %b busy %b want 0 0", resp_valid, busy); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    if ({resp_add, resp_cmd} !== '0) begin errors++; $display("FAIL reset_resp: got %h/%b want 0/00", resp_add, resp_cmd); end
    if ({rd_count, wr_count, rwitm_count} !== '0) begin errors++; $display("FAIL reset_counts: got %0d %0d %0d want 0", rd_count, wr_count, rwitm_count); end
    // A request presented during reset must not be accepted.
    cmd_in = CMD_READ; add_in = 26'h0000ABC;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    tick(CMD_NOP, '0, 1'b0, acc);
  endtask

  task automatic test_single_read();
    int a, resp_cyc = -1, idle_cyc = -1;
    logic [ADDR_W-1:0] seen_add = '0;
    logic acc;
    tick(CMD_NOP, '0, 1'b1, acc);
    send(CMD_READ, 26'h0000123, a);
    for (int k = 0; k < 8; k++) begin
      tick(CMD_NOP, '0, 1'b0, acc);
      if (resp_valid === 1'b1 && resp_cyc < 0) begin resp_cyc = t; seen_add = resp_add; end
      if (busy === 1'b0 && idle_cyc < 0) idle_cyc = t;
    end
    checks += 4;
    if (resp_cyc - a !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", resp_cyc - a); end
    if (seen_add !== 26'h0000123) begin errors++; $display("FAIL single_addr: got %h want 0000123", seen_add); end
    if (idle_cyc - a !== 6) begin errors++; $display("FAIL single_busy_drop: got %0d want 6", idle_cyc - a); end
    if (rd_count !== 4'd1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd_count); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, n = 0;
    int cyc[3];
    logic [ADDR_W+1:0] got[3];
    logic [ADDR_W+1:0] want[3];
    logic acc;
    want[0] = {26'h10, CMD_WRITE}; want[1] = {26'h20, CMD_RWITM}; want[2] = {26'h30, CMD_READ};
    tick(CMD_NOP, '0, 1'b1, acc);
    send(CMD_WRITE, 26'h10, a0);
    send(CMD_RWITM, 26'h20, a1);
    send(CMD_READ, 26'h30, a2);
    for (int k = 0; k < 20; k++) begin
      tick(CMD_NOP, '0, 1'b0, acc);
      if (resp_valid === 1'b1 && n < 3) begin cyc[n] = t; got[n] = {resp_add, resp_cmd}; n++; end
    end
    checks += 5;
    if (a2 - a0 !== 2) begin errors++; $display("FAIL b2b_accept: got span %0d want 2", a2 - a0); end
    if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], want[i]); end
      end
      if (cyc[0] - a0 !== 5 || cyc[1] - cyc[0] !== 5 || cyc[2] - cyc[1] !== 5) begin
        errors++; $display("FAIL b2b_spacing: got %0d %0d %0d want 5 5 5", cyc[0] - a0, cyc[1] - cyc[0], cyc[2] - cyc[1]);
      end
    end
    if ({rd_count, wr_count} !== {4'd1, 4'd1}) begin errors++; $display("FAIL b2b_rd_wr: got %0d %0d want 1 1", rd_count, wr_count); end
    if (rwitm_count !== 4'd1) begin errors++; $display("FAIL b2b_rwitm: got %0d want 1", rwitm_count); end
  endtask

  task automatic test_full();
    int acc_cyc[6];
    int seen0;
    logic acc;
    tick(CMD_NOP, '0, 1'b1, acc);
    seen0 = n_seen;
    for (int i = 0; i < 6; i++) send(CMD_READ, ADDR_W'(32'h100 + i), acc_cyc[i]);
    idle(40);
    checks += 3;
    // Head popped at a+1, four more fill the queue; sixth waits for the next pop.
    if (acc_cyc[5] - acc_cyc[0] !== 7) begin errors++; $display("FAIL full_stall: got %0d want 7", acc_cyc[5] - acc_cyc[0]); end
    if (n_seen - seen0 !== 6) begin errors++; $display("FAIL full_responses: got %0d want 6", n_seen - seen0); end
    if (rd_count !== 4'd6) begin errors++; $display("FAIL full_rd_count: got %0d want 6", rd_count); end
  endtask

  task automatic test_reset_mid();
    int a;
    int seen0;
    for (int i = 0; i < 4; i++) send(CMD_RWITM, ADDR_W'(32'h200 + i), a);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midreset_flags: got v%b b%b r%b want v0 b0 r1", resp_valid, busy, req_ready); end
    if ({rd_count, wr_count, rwitm_count} !== '0) begin errors++; $display("FAIL midreset_counts: got %0d %0d %0d want 0", rd_count, wr_count, rwitm_count); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    seen0 = n_seen;
    idle(20);
    checks++;
    if (n_seen !== seen0) begin errors++; $display("FAIL midreset_stale: got %0d responses want 0", n_seen - seen0); end
  endtask

  task automatic test_saturation();
    int a;
    logic acc = 1'b0;
    tick(CMD_NOP, '0, 1'b1, acc);
    for (int i = 0; i < 16; i++) send(CMD_READ, ADDR_W'(32'h300 + i), a);
    checks++;
    if (rd_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", rd_count); end
    for (int k = 0; k < 50 && !exp_ready; k++) tick(CMD_NOP, '0, 1'b0, acc);
    tick(CMD_READ, 26'h55, 1'b1, acc);
    checks += 2;
    if (acc !== 1'b1) begin errors++; $display("FAIL sat_clr_accept: got %b want 1", acc); end
    if (rd_count !== 4'd0) begin errors++; $display("FAIL sat_clr_priority: got %0d want 0", rd_count); end
    idle(60);
  endtask

  task automatic test_wraparound();
    int a;
    int acc0, seen0;
    logic acc;
    tick(CMD_NOP, '0, 1'b1, acc);
    acc0 = n_acc; seen0 = n_seen;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      idle($urandom_range(0, 2));
      send(2'($urandom_range(1, 3)), ADDR_W'($urandom()), a);
    end
    for (int k = 0; k < 300 && mq.size() > 0; k++) tick(CMD_NOP, '0, 1'b0, acc);
    idle(2);
    checks += 2;
    if (n_acc - acc0 !== 3 * DEPTH) begin errors++; $display("FAIL wrap_accepts: got %0d want %0d", n_acc - acc0, 3 * DEPTH); end
    if (n_seen - seen0 !== 3 * DEPTH) begin errors++; $display("FAIL wrap_responses: got %0d want %0d", n_seen - seen0, 3 * DEPTH); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_saturation();
    test_wraparound();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
